// File: rtl/game_ctrl_if.sv
// Player/frame inputs and status outputs of the game controller.
// btn is a level; refr_tick, hit and miss are single-clock pulses, sampled on the rising clk edge.
interface game_ctrl_if;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] state;
  logic [2:0] lives_left;
  logic [7:0] score_bcd;
  logic       timer_busy;

  modport master (
    output btn, refr_tick, hit, miss,
    input  gra_still, state, lives_left, score_bcd, timer_busy
  );

  modport slave (
    input  btn, refr_tick, hit, miss,
    output gra_still, state, lives_left, score_bcd, timer_busy
  );
endinterface

// File: rtl/game_ctrl.sv
// Game flow controller: new game / play / new ball / game over with a refresh-tick hold-off.
// Define GAME_SCORE_EN to compile in the two-digit BCD score counter.
module game_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic        clk,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] TICKS_INIT = 8'(TIMER_TICKS);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NEWGAME;
      lives_q <= LIVES_INIT;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    timer_d = timer_q;
    if (bus.refr_tick && (timer_q != 8'd0))
      timer_d = timer_q - 8'd1;
    unique case (state_q)
      NEWGAME: begin
        if (bus.btn != 2'b00) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
        end
      end
      PLAY: begin
        // A miss reloads the hold-off, overriding any tick in the same cycle.
        if (bus.miss) begin
          timer_d = TICKS_INIT;
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = NEWBALL;
          end else begin
            lives_d = 3'd0;
            state_d = OVER;
          end
        end
      end
      NEWBALL: begin
        if ((bus.btn != 2'b00) && (timer_q == 8'd0))
          state_d = PLAY;
      end
      OVER: begin
        if (timer_q == 8'd0)
          state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase
  end

`ifdef GAME_SCORE_EN
  logic [7:0] score_q;
  logic       start;
  logic       score_inc;

  assign start     = (state_q == NEWGAME) && (bus.btn != 2'b00);
  assign score_inc = (state_q == PLAY) && bus.hit;

  // BCD increment with saturation at 99.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= 8'h00;
    end else if (start) begin
      score_q <= 8'h00;
    end else if (score_inc && (score_q != 8'h99)) begin
      if (score_q[3:0] == 4'd9)
        score_q <= {score_q[7:4] + 4'd1, 4'd0};
      else
        score_q <= {score_q[7:4], score_q[3:0] + 4'd1};
    end
  end

  assign bus.score_bcd = score_q;
`else
  assign bus.score_bcd = 8'h00;
`endif

  assign bus.state      = state_q;
  assign bus.gra_still  = (state_q != PLAY);
  assign bus.lives_left = lives_q;
  assign bus.timer_busy = (timer_q != 8'd0);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed table, corner sequences and random traffic vs a reference model.
module tb_game_ctrl;
  localparam int LIVES = 3;
  localparam int TICKS = 120;

  logic clk = 1'b0;
  logic reset = 1'b0;

  game_ctrl_if bus ();

  game_ctrl #(.LIVES(LIVES), .TIMER_TICKS(TICKS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];

  // Reference model: game rules expressed with plain integers (score kept in decimal).
  int m_state, m_lives, m_score, m_timer;

  function automatic logic [7:0] to_bcd(int s);
`ifdef GAME_SCORE_EN
    return 8'(((s / 10) << 4) | (s % 10));
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [14:0] model_vec();
    return {2'(m_state), 3'(m_lives), to_bcd(m_score), (m_state != 1), (m_timer != 0)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.state, bus.lives_left, bus.score_bcd, bus.gra_still, bus.timer_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [1:0] b, input logic r, input logic h, input logic m);
    int ns, nl, nsc, nt;
    ns = m_state; nl = m_lives; nsc = m_score; nt = m_timer;
    if (r && m_timer > 0) nt = m_timer - 1;
    if (m_state == 0) begin
      if (b != 0) begin ns = 1; nl = LIVES; nsc = 0; end
    end else if (m_state == 1) begin
      if (h && m_score < 99) nsc = m_score + 1;
      if (m) begin
        nt = TICKS;
        if (m_lives > 1) begin nl = m_lives - 1; ns = 2; end
        else begin nl = 0; ns = 3; end
      end
    end else if (m_state == 2) begin
      if (b != 0 && m_timer == 0) ns = 1;
    end else begin
      if (m_timer == 0) ns = 0;
    end
    m_state = ns; m_lives = nl; m_score = nsc; m_timer = nt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [1:0] b, input logic r, input logic h, input logic m);
    bus.btn = b; bus.refr_tick = r; bus.hit = h; bus.miss = m;
    @(posedge clk);
    model_step(b, r, h, m);
    exp_q.push_back(model_vec());
    #1;
    check("model", 32'(dut_vec()), 32'(exp_q.pop_front()));
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    m_state = 0; m_lives = LIVES; m_score = 0; m_timer = 0;
    check("reset_now", 32'(dut_vec()), 32'({2'd0, 3'(LIVES), 8'h00, 1'b1, 1'b0}));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_holdoff(input logic [1:0] b);
    for (int i = 0; i < TICKS; i++) cycle(b, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0] btn;
    logic       refr;
    logic       hit;
    logic       miss;
    int         st;
    int         lv;
    int         sc;
  } vec_t;

  vec_t tbl[12];

  initial begin : watchdog
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : main
    bus.btn = 2'b00; bus.refr_tick = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;

    tbl[0]  = '{2'b00, 1'b1, 1'b0, 1'b0, 0, 3, 0};
    tbl[1]  = '{2'b00, 1'b0, 1'b1, 1'b1, 0, 3, 0};
    tbl[2]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1, 3, 0};
    tbl[3]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1, 3, 1};
    tbl[4]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1, 3, 2};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1, 3, 2};
    tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1, 3, 3};
    tbl[7]  = '{2'b00, 1'b0, 1'b0, 1'b1, 2, 2, 3};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2, 2, 3};
    tbl[9]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2, 2, 3};
    tbl[10] = '{2'b00, 1'b1, 1'b1, 1'b0, 2, 2, 3};
    tbl[11] = '{2'b11, 1'b0, 1'b1, 1'b1, 2, 2, 3};

    apply_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].btn, tbl[i].refr, tbl[i].hit, tbl[i].miss);
      check($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_lives", i), 32'(bus.lives_left), 32'(tbl[i].lv));
      check($sformatf("tbl%0d_score", i), 32'(bus.score_bcd), 32'(to_bcd(tbl[i].sc)));
    end

    // Start, score run and saturation.
    apply_reset();
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    check("start_state", 32'(bus.state), 32'd1);
    check("start_gra", 32'(bus.gra_still), 32'd0);
    check("start_lives", 32'(bus.lives_left), 32'd3);
    check("start_score", 32'(bus.score_bcd), 32'h00);
    for (int i = 0; i < 12; i++) cycle(2'b00, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
`ifdef GAME_SCORE_EN
    check("score_12", 32'(bus.score_bcd), 32'h12);
`else
    check("score_12", 32'(bus.score_bcd), 32'h00);
`endif
    for (int i = 0; i < 87; i++) cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
`ifdef GAME_SCORE_EN
    check("score_sat", 32'(bus.score_bcd), 32'h99);
`else
    check("score_sat", 32'(bus.score_bcd), 32'h00);
`endif

    // Miss, then a held button must wait out the full hold-off.
    apply_reset();
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    check("miss_state", 32'(bus.state), 32'd2);
    check("miss_lives", 32'(bus.lives_left), 32'd2);
    check("miss_busy", 32'(bus.timer_busy), 32'd1);
    for (int i = 0; i < TICKS; i++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b0);
      check("hold_state", 32'(bus.state), 32'd2);
    end
    check("hold_busy_done", 32'(bus.timer_busy), 32'd0);
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    check("launch_state", 32'(bus.state), 32'd1);

    // Full game to OVER with simultaneous hit and miss on the last ball.
    apply_reset();
    cycle(2'b10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1, 1'b1);
    check("newball_ignore_state", 32'(bus.state), 32'd2);
    check("newball_ignore_lives", 32'(bus.lives_left), 32'd2);
    check("newball_ignore_score", 32'(bus.score_bcd), 32'(to_bcd(5)));
    run_holdoff(2'b00);
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    run_holdoff(2'b00);
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    check("last_ball_lives", 32'(bus.lives_left), 32'd1);
    cycle(2'b00, 1'b0, 1'b1, 1'b1);
    check("over_state", 32'(bus.state), 32'd3);
    check("over_lives", 32'(bus.lives_left), 32'd0);
    check("over_score", 32'(bus.score_bcd), 32'(to_bcd(6)));
    run_holdoff(2'b11);
    check("over_hold_state", 32'(bus.state), 32'd3);
    cycle(2'b00, 1'b0, 1'b1, 1'b1);
    check("newgame_state", 32'(bus.state), 32'd0);
    check("newgame_score_kept", 32'(bus.score_bcd), 32'(to_bcd(6)));
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    check("restart_lives", 32'(bus.lives_left), 32'd3);
    check("restart_score", 32'(bus.score_bcd), 32'h00);

    // Asynchronous reset in NEWBALL with the timer mid-count (57).
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 63; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0);
    check("pre_reset_busy", 32'(bus.timer_busy), 32'd1);
    apply_reset();
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("post_reset_state", 32'(bus.state), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      cycle(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
